// File: rtl/led_ctrl.sv
// led_ctrl: bus-mapped controller for the 8-bit LED bank.
// It holds the DATA, CTRL and PERIOD registers. A prescaler paces a static,
// blink, rotate-left or rotate-right pattern, and the result is registered
// before it goes to the LED driver.
// Optional build macro LED_CTRL_PWM_EN adds a 4-bit duty field in CTRL[7:4].
// When the macro is set, that field gates the LED output from a free-running
// 4-bit PWM counter.
module led_ctrl #(
   parameter int unsigned          PERIOD_W       = 24,
   parameter logic [PERIOD_W-1:0]  DEFAULT_PERIOD = 24'd5000000,
   parameter logic [7:0]           RESET_PATTERN  = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic        w,
   input  logic [1:0]  addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic [7:0]  led_data
);

   localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

   localparam logic [1:0] A_DATA   = 2'd0;
   localparam logic [1:0] A_CTRL   = 2'd1;
   localparam logic [1:0] A_PERIOD = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   localparam logic [1:0] M_STATIC = 2'd0;
   localparam logic [1:0] M_BLINK  = 2'd1;
   localparam logic [1:0] M_ROTL   = 2'd2;
   localparam logic [1:0] M_ROTR   = 2'd3;

   logic [7:0]          pattern;
   logic [1:0]          mode;
   logic                oe;
   logic [PERIOD_W-1:0] period;
   logic [PERIOD_W-1:0] cnt;
   logic [PERIOD_W-1:0] period_last;
   logic                phase;
   logic [7:0]          shreg;
   logic                tick;
   logic                wr_en;
   logic                rd_en;
   logic [7:0]          ctrl_rd;
   logic [7:0]          led_next;
   logic                unused_bits;
`ifdef LED_CTRL_PWM_EN
   logic [3:0]          duty;
   logic [3:0]          pwm_cnt;
`endif

   assign wr_en       = ena & w;
   assign rd_en       = ena & ~w;
   // A period of 0 behaves as 1, so the terminal count is 0 in both cases.
   assign period_last = (period == '0) ? '0 : period - ONE;
   assign tick        = (cnt == period_last);
   assign unused_bits = ^data_in[31:PERIOD_W];

`ifdef LED_CTRL_PWM_EN
   assign ctrl_rd = {duty, 1'b0, oe, mode};
`else
   assign ctrl_rd = {5'b0, oe, mode};
`endif

   // Registers, prescaler and pattern stepping; a write overrides that cycle's step.
   always_ff @(posedge clk) begin
      if (rst) begin
         pattern <= RESET_PATTERN;
         mode    <= M_STATIC;
         oe      <= 1'b1;
         period  <= DEFAULT_PERIOD;
         cnt     <= '0;
         phase   <= 1'b0;
         shreg   <= RESET_PATTERN;
`ifdef LED_CTRL_PWM_EN
         duty    <= 4'hF;
`endif
      end else begin
         cnt <= tick ? '0 : cnt + ONE;
         if (tick) begin
            case (mode)
               M_BLINK: phase <= ~phase;
               M_ROTL:  shreg <= {shreg[6:0], shreg[7]};
               M_ROTR:  shreg <= {shreg[0], shreg[7:1]};
               default: ;
            endcase
         end
         if (wr_en) begin
            case (addr)
               A_DATA: begin
                  pattern <= data_in[7:0];
                  shreg   <= data_in[7:0];
                  phase   <= phase;
               end
               A_CTRL: begin
                  mode  <= data_in[1:0];
                  oe    <= data_in[2];
`ifdef LED_CTRL_PWM_EN
                  duty  <= data_in[7:4];
`endif
                  cnt   <= '0;
                  phase <= 1'b0;
                  shreg <= pattern;
               end
               A_PERIOD: begin
                  period <= data_in[PERIOD_W-1:0];
                  cnt    <= '0;
                  phase  <= 1'b0;
                  shreg  <= pattern;
               end
               default: ;
            endcase
         end
      end
   end

   // LED value from the current state, optionally gated by the PWM duty.
   always_comb begin
      led_next = 8'h00;
      if (oe) begin
         case (mode)
            M_STATIC: led_next = pattern;
            M_BLINK:  led_next = phase ? 8'h00 : pattern;
            default:  led_next = shreg;
         endcase
      end
`ifdef LED_CTRL_PWM_EN
      if (pwm_cnt > duty) led_next = 8'h00;
`endif
   end

`ifdef LED_CTRL_PWM_EN
   // Free-running PWM phase counter.
   always_ff @(posedge clk) begin
      if (rst) pwm_cnt <= 4'h0;
      else     pwm_cnt <= pwm_cnt + 4'h1;
   end
`endif

   // Registered LED output and read data; data_out holds when not read.
   always_ff @(posedge clk) begin
      if (rst) begin
         led_data <= 8'h00;
         data_out <= 32'h0;
      end else begin
         led_data <= led_next;
         if (rd_en) begin
            case (addr)
               A_DATA:   data_out <= {24'h0, pattern};
               A_CTRL:   data_out <= {24'h0, ctrl_rd};
               A_PERIOD: data_out <= {{(32-PERIOD_W){1'b0}}, period};
               A_STATUS: data_out <= {23'h0, phase, led_data};
               default:  data_out <= 32'h0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: directed checks of the led_ctrl register interface and LED patterns.
module tb_led_ctrl;

   localparam logic [7:0]  RP = 8'h3C;
   localparam logic [23:0] DP = 24'd5000000;
`ifdef LED_CTRL_PWM_EN
   localparam logic [7:0]  CTRL_RST = 8'hF4;
   localparam logic [7:0]  CTRL_FD  = 8'hF5;
`else
   localparam logic [7:0]  CTRL_RST = 8'h04;
   localparam logic [7:0]  CTRL_FD  = 8'h05;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic        w;
   logic [1:0]  addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic [7:0]  led_data;

   int n_pass = 0;
   int n_tot  = 0;

   led_ctrl #(
      .PERIOD_W(24),
      .DEFAULT_PERIOD(DP),
      .RESET_PATTERN(RP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .ena(ena),
      .w(w),
      .addr(addr),
      .data_in(data_in),
      .data_out(data_out),
      .led_data(led_data)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      ena = 1'b1; w = 1'b1; addr = a; data_in = d;
      step();
      ena = 1'b0; w = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a);
      ena = 1'b1; w = 1'b0; addr = a;
      step();
      ena = 1'b0;
   endtask

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      logic [7:0] r;
      r = x;
      for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
      return r;
   endfunction

   function automatic logic [7:0] rotr(input logic [7:0] x, input int n);
      logic [7:0] r;
      r = x;
      for (int k = 0; k < n; k++) r = {r[0], r[7:1]};
      return r;
   endfunction

   initial begin
      rst = 1'b1; ena = 1'b0; w = 1'b0; addr = 2'd0; data_in = 32'h0;

      // Reset and reset values
      step();
      step();
      check("rst_led", {24'h0, led_data}, 32'h00);
      check("rst_dout", data_out, 32'h0);
      rst = 1'b0;
      step();
      check("post_rst_led", {24'h0, led_data}, {24'h0, RP});
      rd(2'd1);
      check("rst_ctrl", data_out, {24'h0, CTRL_RST});
      rd(2'd2);
      check("rst_period", data_out, {8'h0, DP});
      rd(2'd0);
      check("rst_data", data_out, {24'h0, RP});

      // Blink, PERIOD 4, with STATUS read continuously
      wr(2'd0, 32'hA5);
      wr(2'd2, 32'd4);
      wr(2'd1, 32'h05);
      ena = 1'b1; w = 1'b0; addr = 2'd3;
      for (int i = 0; i < 16; i++) begin
         step();
         check($sformatf("blink_led[%0d]", i), {24'h0, led_data},
               ((i / 4) % 2 == 0) ? 32'hA5 : 32'h00);
         check($sformatf("blink_phase[%0d]", i), {31'h0, data_out[8]},
               ((i / 4) % 2 == 0) ? 32'h0 : 32'h1);
      end
      ena = 1'b0;

      // Rotate-left, PERIOD 3
      wr(2'd2, 32'd3);
      wr(2'd0, 32'h81);
      wr(2'd1, 32'h06);
      for (int i = 0; i < 12; i++) begin
         step();
         check($sformatf("rotl_led[%0d]", i), {24'h0, led_data}, {24'h0, rotl(8'h81, i / 3)});
      end

      // Rotate-right, PERIOD 3
      wr(2'd1, 32'h07);
      for (int i = 0; i < 9; i++) begin
         step();
         check($sformatf("rotr_led[%0d]", i), {24'h0, led_data}, {24'h0, rotr(8'h81, i / 3)});
      end

      // PERIOD 0 behaves as 1: step every cycle, wrap 80 -> 01
      wr(2'd0, 32'h01);
      wr(2'd1, 32'h06);
      wr(2'd2, 32'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("p0_led[%0d]", i), {24'h0, led_data}, {24'h0, rotl(8'h01, i)});
      end

      // DATA write on the tick edge wins over the rotate step
      wr(2'd2, 32'd3);
      step();
      step();
      wr(2'd0, 32'h0F);
      check("coll_before", {24'h0, led_data}, 32'h01);
      step();
      check("coll_after", {24'h0, led_data}, 32'h0F);
      wr(2'd1, 32'h02);
      step();
      check("oe_off_led", {24'h0, led_data}, 32'h00);

      // Back-to-back reads: STATUS then DATA
      wr(2'd2, 32'd2);
      wr(2'd1, 32'h05);
      step();
      step();
      ena = 1'b1; w = 1'b0; addr = 2'd3;
      step();
      check("rd_status", data_out, 32'h10F);
      addr = 2'd0;
      step();
      check("rd_data", data_out, 32'h0F);
      ena = 1'b0;
      step();
      check("rd_hold", data_out, 32'h0F);

      // STATUS write ignored; reserved CTRL bits
      wr(2'd3, 32'hFFFF_FFFF);
      rd(2'd0);
      check("status_wr_data", data_out, 32'h0F);
      rd(2'd2);
      check("status_wr_period", data_out, 32'd2);
      wr(2'd1, 32'hFD);
      rd(2'd1);
      check("ctrl_reserved", data_out, {24'h0, CTRL_FD});

      // Reset mid-operation with a concurrent write
      rst = 1'b1; ena = 1'b1; w = 1'b1; addr = 2'd0; data_in = 32'h55;
      step();
      rst = 1'b0; ena = 1'b0; w = 1'b0;
      check("mid_rst_led", {24'h0, led_data}, 32'h00);
      check("mid_rst_dout", data_out, 32'h0);
      step();
      check("mid_rst_led2", {24'h0, led_data}, {24'h0, RP});
      rd(2'd0);
      check("mid_rst_data", data_out, {24'h0, RP});
      rd(2'd1);
      check("mid_rst_ctrl", data_out, {24'h0, CTRL_RST});

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
